// File: rtl/rule_loader.sv
// Host-side rule writer: gathers NWORDS config words into one {mask, rule} vector for the match memory.
// Optional RULE_LOADER_MASK_NORMALIZE_EN forces don't-care key bits to zero in the presented rule.
module rule_loader #(
  parameter int unsigned CONCAT_WIDTH = 104,
  parameter int unsigned MASK_WIDTH   = 104,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned MAX_RULES    = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [WORD_WIDTH-1:0]              cfg_data,
  input  logic                               cfg_last,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  output logic [CONCAT_WIDTH+MASK_WIDTH-1:0] newrule,
  output logic                               newrule_valid,
  input  logic                               newrule_ready,
  input  logic                               rule_clear,
  output logic [3:0]                         rule_count,
  output logic                               err_short,
  output logic                               err_long,
  output logic                               err_full
);

  localparam int unsigned TOTAL  = CONCAT_WIDTH + MASK_WIDTH;
  localparam int unsigned NWORDS = (TOTAL + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned CntW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CntW-1:0] LastIdx  = CntW'(NWORDS - 1);
  localparam logic [3:0]      MaxCount = 4'(MAX_RULES);

  typedef enum logic [1:0] {StCollect, StSend, StDrop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      count_q, count_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            full_q, full_d;
  logic [TOTAL-1:0] asm_q;
  logic            store;

  assign store = cfg_valid && (state_q == StCollect);

  // One register slice per word; the last slice keeps only the bits that fit in TOTAL.
  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    localparam int unsigned Lo = k * WORD_WIDTH;
    localparam int unsigned Wd = ((TOTAL - Lo) < WORD_WIDTH) ? (TOTAL - Lo) : WORD_WIDTH;
    logic [Wd-1:0] word_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        word_q <= '0;
      end else if (store && (cnt_q == CntW'(k))) begin
        word_q <= cfg_data[Wd-1:0];
      end
    end

    assign asm_q[Lo +: Wd] = word_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StCollect;
      cnt_q   <= '0;
      count_q <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      short_q <= short_d;
      long_q  <= long_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    full_d  = 1'b0;
    // Clear is applied before any same-cycle increment.
    if (rule_clear) count_d = '0;
    unique case (state_q)
      StCollect: begin
        if (cfg_valid) begin
          if (cnt_q == LastIdx) begin
            cnt_d = '0;
            if (!cfg_last) begin
              long_d  = 1'b1;
              state_d = StDrop;
            end else if (count_q < MaxCount) begin
              state_d = StSend;
            end else begin
              full_d = 1'b1;
            end
          end else if (cfg_last) begin
            short_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StSend: begin
        if (newrule_ready) begin
          state_d = StCollect;
          cnt_d   = '0;
          if (count_d < MaxCount) count_d = count_d + 4'd1;
        end
      end
      StDrop: begin
        if (cfg_valid && cfg_last) begin
          state_d = StCollect;
          cnt_d   = '0;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  assign cfg_ready     = (state_q != StSend);
  assign newrule_valid = (state_q == StSend);
  assign rule_count    = count_q;
  assign err_short     = short_q;
  assign err_long      = long_q;
  assign err_full      = full_q;

`ifdef RULE_LOADER_MASK_NORMALIZE_EN
  // Assumes MASK_WIDTH == CONCAT_WIDTH so mask bits line up with key bits.
  assign newrule = {asm_q[TOTAL-1:CONCAT_WIDTH],
                    asm_q[CONCAT_WIDTH-1:0] & asm_q[TOTAL-1:CONCAT_WIDTH]};
`else
  assign newrule = asm_q;
`endif

endmodule

// File: tb/tb_rule_loader.sv
// Self-checking bench for rule_loader: queue-based reference model, directed scenarios, random traffic.
module tb_rule_loader;

  localparam int NW  = 7;
  localparam int TW  = 208;
  localparam int KW  = 104;
  localparam int MAXR = 8;

  logic          clock;
  logic          reset;
  logic [31:0]   cfg_data;
  logic          cfg_last;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [TW-1:0] newrule;
  logic          newrule_valid;
  logic          newrule_ready;
  logic          rule_clear;
  logic [3:0]    rule_count;
  logic          err_short;
  logic          err_long;
  logic          err_full;

  rule_loader dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .newrule      (newrule),
    .newrule_valid(newrule_valid),
    .newrule_ready(newrule_ready),
    .rule_clear   (rule_clear),
    .rule_count   (rule_count),
    .err_short    (err_short),
    .err_long     (err_long),
    .err_full     (err_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int n_short = 0, n_long = 0, n_full = 0;
  bit rand_mode = 0;

  // Reference model: words of the rule in progress, plus flags for pending delivery / discard.
  logic [31:0]   m_words[$];
  bit            m_sending = 0;
  bit            m_dropping = 0;
  int            m_count = 0;
  logic [TW-1:0] m_rule = '0;
  bit            e_short = 0, e_long = 0, e_full = 0;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] pack_rule();
    logic [NW*32-1:0] w;
    logic [TW-1:0]    r;
    w = '0;
    for (int k = 0; k < NW; k++) w[k*32 +: 32] = m_words[k];
    r = w[TW-1:0];
`ifdef RULE_LOADER_MASK_NORMALIZE_EN
    r[KW-1:0] = r[KW-1:0] & r[TW-1:KW];
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_sending  = 0;
    m_dropping = 0;
    m_count    = 0;
    e_short    = 0;
    e_long     = 0;
    e_full     = 0;
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        model_reset();
      end else begin
        int nc;
        e_short = 0;
        e_long  = 0;
        e_full  = 0;
        nc = rule_clear ? 0 : m_count;
        if (m_sending) begin
          if (newrule_ready) begin
            m_sending = 0;
            if (nc < MAXR) nc++;
          end
        end else if (cfg_valid) begin
          if (m_dropping) begin
            if (cfg_last) m_dropping = 0;
          end else begin
            m_words.push_back(cfg_data);
            if (m_words.size() == NW) begin
              if (!cfg_last) begin
                e_long = 1;
                m_dropping = 1;
              end else if (m_count < MAXR) begin
                m_sending = 1;
                m_rule = pack_rule();
              end else begin
                e_full = 1;
              end
              m_words.delete();
            end else if (cfg_last) begin
              e_short = 1;
              m_words.delete();
            end
          end
        end
        m_count = nc;
      end
    end
  end

  // Compare process: outputs sampled mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      check("cfg_ready", cfg_ready, !m_sending);
      check("newrule_valid", newrule_valid, m_sending);
      if (m_sending) check("newrule", newrule, m_rule);
      check("rule_count", rule_count, m_count);
      check("err_short", err_short, e_short);
      check("err_long", err_long, e_long);
      check("err_full", err_full, e_full);
      if (err_short) n_short++;
      if (err_long)  n_long++;
      if (err_full)  n_full++;
    end
  end

  // Random-mode drivers for handshake back-pressure and clear pulses.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_mode) begin
        newrule_ready = ($urandom % 3) != 0;
        rule_clear    = ($urandom % 20) == 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    bit acc, rdy;
    cfg_data  = d;
    cfg_last  = last;
    cfg_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clock);
      rdy = cfg_ready;
      step();
      if (rdy) acc = 1;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL word_accept: got no cfg_ready, expected acceptance within 200 cycles");
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (rand_mode && ($urandom % 3) == 0) step();
  endtask

  // lastpos = 0 means no word carries cfg_last.
  task automatic send_rule(input int n, input int lastpos, input bit seq);
    for (int i = 1; i <= n; i++) send_word(seq ? 32'(i) : $urandom, i == lastpos);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100 && newrule_valid; i++) step();
    if (newrule_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: got newrule_valid=1, expected 0 within 100 cycles");
    end
  endtask

  int s0;

  initial begin
    reset = 1'b0;
    cfg_data = '0;
    cfg_last = 1'b0;
    cfg_valid = 1'b0;
    newrule_ready = 1'b0;
    rule_clear = 1'b0;
    repeat (3) step();
    check("reset_newrule", newrule, '0);
    check("reset_cfg_ready", cfg_ready, 1);
    reset = 1'b1;
    step();

    // Sequential words 1..7 delivered one cycle after the last handshake.
    newrule_ready = 1'b1;
    check("count_before", rule_count, 0);
    send_rule(7, 7, 1);
    check("lat_valid", newrule_valid, 1);
    check("word0", newrule[31:0], 32'd1);
    check("word1", newrule[63:32], 32'd2);
    step();
    check("count_after", rule_count, 1);

    // Short rule, then a correct one.
    s0 = n_short;
    send_rule(3, 3, 0);
    repeat (2) step();
    check("short_pulses", n_short - s0, 1);
    send_rule(7, 7, 0);
    wait_idle();
    check("count_after_short", rule_count, 2);

    // Long rule: 9 words, last on the 9th.
    s0 = n_long;
    send_rule(9, 9, 0);
    repeat (2) step();
    check("long_pulses", n_long - s0, 1);
    check("count_after_long", rule_count, 2);

    // Fill the table from empty: 9 rules, the 9th is dropped.
    rule_clear = 1'b1;
    step();
    rule_clear = 1'b0;
    check("count_cleared", rule_count, 0);
    s0 = n_full;
    for (int r = 0; r < 9; r++) begin
      send_rule(7, 7, 0);
      wait_idle();
    end
    step();
    check("count_full", rule_count, 8);
    check("full_pulses", n_full - s0, 1);
    rule_clear = 1'b1;
    step();
    rule_clear = 1'b0;
    check("count_clear2", rule_count, 0);
    send_rule(7, 7, 0);
    wait_idle();
    check("count_post_clear", rule_count, 1);

    // Back-pressure for 10 cycles, then clear on the handshake cycle.
    newrule_ready = 1'b0;
    send_rule(7, 7, 0);
    repeat (10) step();
    check("stall_valid", newrule_valid, 1);
    check("stall_ready", cfg_ready, 0);
    rule_clear = 1'b1;
    newrule_ready = 1'b1;
    step();
    rule_clear = 1'b0;
    check("clear_on_handshake", rule_count, 1);

    // Asynchronous reset while a rule is pending.
    newrule_ready = 1'b0;
    send_rule(7, 7, 0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_valid", newrule_valid, 0);
    check("async_count", rule_count, 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("post_reset_ready", cfg_ready, 1);
    newrule_ready = 1'b1;
    send_rule(7, 7, 1);
    check("post_reset_word0", newrule[31:0], 32'd1);
    wait_idle();

    // Random traffic.
    rand_mode = 1;
    for (int r = 0; r < 60; r++) begin
      int n, lp;
      n  = $urandom_range(1, 9);
      lp = (($urandom % 4) != 0) ? n : $urandom_range(0, n);
      send_rule(n, lp, 0);
      if (($urandom % 4) == 0) repeat ($urandom_range(1, 3)) step();
    end
    rand_mode = 0;
    step();
    newrule_ready = 1'b1;
    rule_clear = 1'b0;
    wait_idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
